// File: rtl/branch_predict_table.sv
// Direct-mapped branch target buffer: fetch lookup, decode-stage pipeline register, resolved-branch update.
// Latency: H/P/target combinational from pc_f; Hd/Pd/pc_d one cycle later. Optional same-cycle forwarding under BPT_BYPASS_EN.
// Backpressure: stall holds the decode register, flush_s1 squashes it; table writes proceed regardless of either.
module branch_predict_table #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_f,
    output logic              H,
    output logic              P,
    output logic [ADDR_W-1:0] target,
    output logic              Hd,
    output logic              Pd,
    output logic [ADDR_W-1:0] pc_d,
    input  logic              Wrt,
    input  logic              Wrp,
    input  logic              c,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              stall,
    input  logic              flush_s1,
    input  logic              inv_all,
    output logic [IDX_W:0]    occ
);

    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef struct packed {
        logic              vld;
        logic              pred;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] tgt;
    } entry_t;

    entry_t bpt_q [ENTRIES];

    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_d;
    logic [TAG_W-1:0] tag_f;
    logic [TAG_W-1:0] tag_d;
    entry_t           ent_f;
    logic             hit;
    logic             pred;
    logic [ADDR_W-1:0] tgt;

    assign idx_f = pc_f[IDX_W+1:2];
    assign tag_f = pc_f[ADDR_W-1:IDX_W+2];
    assign idx_d = pc_d[IDX_W+1:2];
    assign tag_d = pc_d[ADDR_W-1:IDX_W+2];
    assign ent_f = bpt_q[idx_f];

    always_comb begin
        hit  = ent_f.vld && (ent_f.tag == tag_f);
        pred = ent_f.pred;
        tgt  = ent_f.tgt;
`ifdef BPT_BYPASS_EN
        // Forward an update aimed at exactly the PC being fetched this cycle.
        if ((idx_d == idx_f) && (tag_d == tag_f)) begin
            if (Wrt) begin
                hit = 1'b1;
                tgt = upd_target;
            end
            if (Wrp) begin
                pred = c;
            end
        end
`endif
        H      = hit;
        P      = hit & pred;
        target = tgt;
    end

    // Decode-stage register: flush beats stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Hd   <= 1'b0;
            Pd   <= 1'b0;
            pc_d <= '0;
        end else if (flush_s1) begin
            Hd   <= 1'b0;
            Pd   <= 1'b0;
            pc_d <= pc_f;
        end else if (!stall) begin
            Hd   <= H;
            Pd   <= P;
            pc_d <= pc_f;
        end
    end

    // Write of the decode-stage entry is ordered after inv_all so a coincident allocate survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bpt_q[i] <= '0;
            end
        end else begin
            if (inv_all) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    bpt_q[i].vld <= 1'b0;
                end
            end
            if (Wrt) begin
                bpt_q[idx_d].vld <= 1'b1;
                bpt_q[idx_d].tag <= tag_d;
                bpt_q[idx_d].tgt <= upd_target;
            end
            if (Wrp) begin
                bpt_q[idx_d].pred <= c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else if (inv_all) begin
            occ <= Wrt ? {{IDX_W{1'b0}}, 1'b1} : '0;
        end else if (Wrt && !bpt_q[idx_d].vld) begin
            occ <= occ + {{IDX_W{1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_branch_predict_table.sv
// Directed bench for branch_predict_table with hand-computed expectations.
module tb_branch_predict_table;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_f;
    logic        H, P, Hd, Pd;
    logic [31:0] target, pc_d;
    logic        Wrt, Wrp, c;
    logic [31:0] upd_target;
    logic        stall, flush_s1, inv_all;
    logic [4:0]  occ;

    int checks = 0;
    int errors = 0;

    branch_predict_table #(.ENTRIES(16), .IDX_W(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .H(H), .P(P), .target(target),
        .Hd(Hd), .Pd(Pd), .pc_d(pc_d), .Wrt(Wrt), .Wrp(Wrp), .c(c),
        .upd_target(upd_target), .stall(stall), .flush_s1(flush_s1),
        .inv_all(inv_all), .occ(occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; pc_f = 32'h100; Wrt = 0; Wrp = 0; c = 0; upd_target = 0;
        stall = 0; flush_s1 = 0; inv_all = 0;
        #2;
        chk("rst_H", {31'b0, H}, 0);
        chk("rst_P", {31'b0, P}, 0);
        chk("rst_occ", {27'b0, occ}, 0);
        chk("rst_pc_d", pc_d, 0);
        #1 rst_n = 1'b1;
        tick();
        chk("first_Hd", {31'b0, Hd}, 0);
        chk("first_Pd", {31'b0, Pd}, 0);
        chk("first_pc_d", pc_d, 32'h100);

        // Allocate 0x100 taken -> 0x200
        Wrt = 1; Wrp = 1; c = 1; upd_target = 32'h200;
        tick();
        Wrt = 0; Wrp = 0; #1;
        chk("alloc_H", {31'b0, H}, 1);
        chk("alloc_P", {31'b0, P}, 1);
        chk("alloc_target", target, 32'h200);
        chk("alloc_occ", {27'b0, occ}, 1);
        pc_f = 32'h140; #1;
        chk("other_tag_H", {31'b0, H}, 0);

        // Flip prediction to not-taken
        pc_f = 32'h100;
        tick();
        chk("pipe_Hd", {31'b0, Hd}, 1);
        chk("pipe_Pd", {31'b0, Pd}, 1);
        Wrp = 1; c = 0;
        tick();
        Wrp = 0; #1;
        chk("nt_H", {31'b0, H}, 1);
        chk("nt_P", {31'b0, P}, 0);
        chk("nt_occ", {27'b0, occ}, 1);

        // Back to taken, then flush and stall behaviour
        Wrp = 1; c = 1;
        tick();
        Wrp = 0; flush_s1 = 1;
        tick();
        flush_s1 = 0;
        chk("flush_Hd", {31'b0, Hd}, 0);
        chk("flush_Pd", {31'b0, Pd}, 0);
        chk("flush_pc_d", pc_d, 32'h100);
        tick();
        chk("unflush_Hd", {31'b0, Hd}, 1);
        chk("unflush_Pd", {31'b0, Pd}, 1);
        stall = 1; pc_f = 32'h140;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_Hd", {31'b0, Hd}, 1);
            chk("stall_Pd", {31'b0, Pd}, 1);
            chk("stall_pc_d", pc_d, 32'h100);
        end
        flush_s1 = 1;
        tick();
        chk("flush_over_stall_Hd", {31'b0, Hd}, 0);
        chk("flush_over_stall_pc_d", pc_d, 32'h140);
        flush_s1 = 0; stall = 0;

        // Fill all 16 indices; index 0 is a replacement of the 0x100 entry
        for (int i = 0; i < 16; i++) begin
            pc_f = 32'h1000 + 32'(i * 4);
            tick();
            Wrt = 1; upd_target = 32'h8000 + 32'(i);
            tick();
            Wrt = 0;
        end
        chk("fill_occ", {27'b0, occ}, 16);
        pc_f = 32'h1014; #1;
        chk("fill_H5", {31'b0, H}, 1);
        chk("fill_target5", target, 32'h8005);
        pc_f = 32'h103C;
        Wrt = 1; upd_target = 32'h9000;
        tick();
        Wrt = 0;
        chk("replace_occ", {27'b0, occ}, 16);
        chk("replace_target", target, 32'h9000);
        inv_all = 1;
        tick();
        inv_all = 0;
        chk("inv_occ", {27'b0, occ}, 0);
        for (int i = 0; i < 16; i++) begin
            pc_f = 32'h1000 + 32'(i * 4); #1;
            chk("inv_H", {31'b0, H}, 0);
        end

        // inv_all with coincident allocate; prediction bit of index 0 survives
        pc_f = 32'h1000;
        tick();
        inv_all = 1; Wrt = 1; upd_target = 32'hA000;
        tick();
        inv_all = 0; Wrt = 0;
        chk("inv_wrt_occ", {27'b0, occ}, 1);
        chk("inv_wrt_H", {31'b0, H}, 1);
        chk("persist_P", {31'b0, P}, 1);
        pc_f = 32'h1004; #1;
        chk("inv_wrt_other_H", {31'b0, H}, 0);

        // Same-cycle write and lookup at 0x300
        pc_f = 32'h300;
        tick();
        Wrt = 1; upd_target = 32'h380; #1;
`ifdef BPT_BYPASS_EN
        chk("same_cycle_H", {31'b0, H}, 1);
        chk("same_cycle_target", target, 32'h380);
`else
        chk("same_cycle_H", {31'b0, H}, 0);
`endif
        tick();
        Wrt = 0; #1;
        chk("next_cycle_H", {31'b0, H}, 1);
        chk("next_cycle_target", target, 32'h380);
        chk("next_cycle_occ", {27'b0, occ}, 1);

        // Asynchronous reset mid-run
        #2 rst_n = 1'b0; #1;
        chk("arst_occ", {27'b0, occ}, 0);
        chk("arst_H", {31'b0, H}, 0);
        chk("arst_pc_d", pc_d, 0);
        chk("arst_Hd", {31'b0, Hd}, 0);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_table.md
BRANCH_PREDICT_TABLE -- requirements
Module: branch_predict_table

Interface
REQ-001 SHALL have parameter ENTRIES, 16, number of direct-mapped entries (power of 2).
REQ-002 SHALL have parameter IDX_W, 4, log2(ENTRIES).
REQ-003 SHALL have parameter ADDR_W, 32, PC width; tag = PC[ADDR_W-1:IDX_W+2].
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pc_f  in  ADDR_W  fetch-stage lookup PC; index = pc_f[IDX_W+1:2].
REQ-007 SHALL have port H  out  1  fetch hit: entry valid and tag equal.
REQ-008 SHALL have port P  out  1  fetch prediction: H AND stored prediction bit.
REQ-009 SHALL have port target  out  ADDR_W  stored target of indexed entry (don't-care when H=0).
REQ-010 SHALL have port Hd  out  1  registered H of the instruction now in decode.
REQ-011 SHALL have port Pd  out  1  registered P of the instruction now in decode.
REQ-012 SHALL have port pc_d  out  ADDR_W  registered pc_f of the instruction now in decode.
REQ-013 SHALL have port Wrt  in  1  allocate: write valid, tag, target at pc_d index.
REQ-014 SHALL have port Wrp  in  1  write prediction bit at pc_d index.
REQ-015 SHALL have port c  in  1  resolved branch outcome (1 = taken) written by Wrp.
REQ-016 SHALL have port upd_target  in  ADDR_W  resolved target written by Wrt.
REQ-017 SHALL have port stall  in  1  hold Hd/Pd/pc_d.
REQ-018 SHALL have port flush_s1  in  1  squash the instruction entering decode.
REQ-019 SHALL have port inv_all  in  1  invalidate all entries.
REQ-020 SHALL have port occ  out  IDX_W+1  count of valid entries.

Function
REQ-021 H, P, target SHALL be combinational from pc_f and table state; zero-cycle lookup latency.
REQ-022 Each edge, flush_s1=1 SHALL load Hd=0, Pd=0, pc_d=pc_f (priority over stall).
REQ-023 Else stall=1 SHALL hold Hd, Pd, pc_d; else they SHALL load H, P, pc_f (1-cycle latency).
REQ-024 Wrt=1 SHALL set valid=1, tag=pc_d tag, target=upd_target at pc_d index on the edge; prediction bit untouched unless Wrp=1.
REQ-025 Wrp=1 SHALL set prediction bit = c at pc_d index; valid/tag/target untouched unless Wrt=1.
REQ-026 Table writes SHALL occur independent of stall and flush_s1.
REQ-027 Without bypass, a lookup at an index written in the same cycle SHALL return pre-write contents.
REQ-028 occ SHALL increment by 1 on Wrt to a previously invalid entry; unchanged on Wrt to a valid entry (replacement); never exceeds ENTRIES.
REQ-029 inv_all=1 SHALL clear all valid bits and occ; if Wrt coincides, that entry ends valid and occ=1.
REQ-030 Prediction bits SHALL persist across inv_all; only valid is cleared.

Reset
REQ-031 rst_n=0 SHALL immediately clear all valid, prediction, tag and target bits and set Hd=0, Pd=0, pc_d=0, occ=0; H=P=0 follows combinationally.
REQ-032 Deassertion SHALL take effect on the first rising edge after rst_n=1; writes during reset are discarded.

Configuration
REQ-033 Macro BPT_BYPASS_EN defined: when Wrt/Wrp targets the index and tag of pc_f in the same cycle, H/P/target SHALL reflect the written values combinationally.
REQ-034 Macro BPT_BYPASS_EN undefined: REQ-027 applies; no forwarding logic is present.

Verification
REQ-035 Reset, pc_f=0x100 -> H=0, P=0, occ=0; next edge Hd=0, Pd=0, pc_d=0x100.
REQ-036 pc_d=0x100, Wrt=Wrp=1, c=1, upd_target=0x200; then pc_f=0x100 -> H=1, P=1, target=0x200, occ=1; pc_f=0x140 (same index, other tag) -> H=0.
REQ-037 Entry 0x100 valid taken; Wrp=1, c=0 at pc_d=0x100 -> lookup H=1, P=0, occ stays 1.
REQ-038 Lookup hit at 0x100 with flush_s1=1 -> next edge Hd=0, Pd=0; with stall=1 instead -> Hd/Pd/pc_d held for all stalled cycles.
REQ-039 Fill 16 distinct indices via Wrt -> occ=16; 17th Wrt to existing index -> occ=16; inv_all=1 -> occ=0, all H=0.
REQ-040 Same-cycle Wrt at pc_d=pc_f=0x300 -> H=1 with BPT_BYPASS_EN, H=0 without; H=1 next cycle in both.
